// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: mode codes, FSM states
// and a ceiling-division helper used for latency arithmetic.
package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data_i by amt_i bits per mode and
// reports the last bit pushed out (0 when amt_i is zero).
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [2:0]         mode_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               last_o
);

    logic [SHAMT_W:0]   inv_amt;
    logic [SHAMT_W-1:0] amt_m1;
    logic [WIDTH-1:0]   lo_mask;
    logic [WIDTH-1:0]   hi_mask;
    logic               left_bit;
    logic               right_bit;

    // Left modes lose bit WIDTH-amt last; right modes lose bit amt-1 last.
    always_comb begin
        inv_amt   = (SHAMT_W+1)'(WIDTH) - {1'b0, amt_i};
        amt_m1    = amt_i - SHAMT_W'(1);
        lo_mask   = WIDTH'(1) << amt_m1;
        hi_mask   = {1'b1, {(WIDTH-1){1'b0}}} >> amt_m1;
        left_bit  = |(data_i & hi_mask);
        right_bit = |(data_i & lo_mask);
        data_o    = data_i;
        last_o    = 1'b0;
        case (mode_i)
            MODE_SLL: begin
                data_o = data_i << amt_i;
                last_o = left_bit;
            end
            MODE_SRL: begin
                data_o = data_i >> amt_i;
                last_o = right_bit;
            end
            MODE_SRA: begin
                data_o = $signed(data_i) >>> amt_i;
                last_o = right_bit;
            end
            MODE_ROL: begin
                data_o = (data_i << amt_i) | (data_i >> inv_amt);
                last_o = left_bit;
            end
            MODE_ROR: begin
                data_o = (data_i >> amt_i) | (data_i << inv_amt);
                last_o = right_bit;
            end
            default: ;
        endcase
        if (amt_i == '0) begin
            last_o = 1'b0;
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: shifts up to STEP bits per clock with a
// start/done handshake, registered result, carry-out and zero flag.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   hyrja,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dalja,
    output logic               carry,
    output logic               zero
);

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic [2:0]         mode_q,  mode_d;
    logic [SHAMT_W-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0]   dalja_q, dalja_d;
    logic               carry_q, carry_d;
    logic               zero_q,  zero_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   step_data;
    logic               step_last;

    // Never step past the remaining count, so the final step is exact.
    assign step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .data_i (work_q),
        .mode_i (mode_q),
        .amt_i  (step_amt),
        .data_o (step_data),
        .last_o (step_last)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        dalja_d = dalja_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                work_d = step_data;
                rem_d  = rem_q - step_amt;
                if (rem_d == '0) begin
                    state_d = ST_FINISH;
                    dalja_d = step_data;
                    carry_d = step_last;
                    zero_d  = (step_data == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    work_d = hyrja;
                    mode_d = mode;
                    rem_d  = shamt;
                    // Zero shift or reserved mode completes immediately as a pass-through.
                    if (shamt == '0 || mode > MODE_ROR) begin
                        state_d = ST_FINISH;
                        dalja_d = hyrja;
                        carry_d = 1'b0;
                        zero_d  = (hyrja == '0);
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            mode_q  <= MODE_SLL;
            rem_q   <= '0;
            dalja_q <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            dalja_q <= dalja_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign dalja = dalja_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: STEP=1 and STEP=4 instances share stimulus and are
// checked every cycle against a transaction-level model plus literal results.
module tb_shift_unit_seq;
    import shift_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  mode;
    logic [15:0] hyrja;
    logic [3:0]  shamt;

    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] dalja_w [2];
    logic        carry_w [2];
    logic        zero_w  [2];

    int n_cmp = 0;
    int n_bad = 0;

    shift_unit_seq #(.WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hyrja(hyrja), .shamt(shamt),
        .busy(busy_w[0]), .done(done_w[0]), .dalja(dalja_w[0]), .carry(carry_w[0]), .zero(zero_w[0])
    );

    shift_unit_seq #(.WIDTH(16), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hyrja(hyrja), .shamt(shamt),
        .busy(busy_w[1]), .done(done_w[1]), .dalja(dalja_w[1]), .carry(carry_w[1]), .zero(zero_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Single-cycle reference operation on a 16-bit operand.
    function automatic void ref_op(input logic [2:0] md, input logic [15:0] a, input int n,
                                   output logic [15:0] r, output bit c);
        int ai;
        int sx;
        int rr;
        ai = int'(a);
        sx = (ai ^ 'h8000) - 'h8000;
        case (md)
            3'd0:    rr = ai << n;
            3'd1:    rr = ai >> n;
            3'd2:    rr = sx >>> n;
            3'd3:    rr = (ai << n) | (ai >> (16 - n));
            3'd4:    rr = (ai >> n) | (ai << (16 - n));
            default: rr = ai;
        endcase
        r = rr[15:0];
        if (n == 0 || md > 3'd4)          c = 1'b0;
        else if (md == 3'd0 || md == 3'd3) c = bit'((ai >> (16 - n)) & 1);
        else                               c = bit'((ai >> (n - 1)) & 1);
    endfunction

    // Transaction-level model: cycles remaining until done, plus pending result.
    int          m_cnt   [2];
    bit          m_busy  [2];
    bit          m_done  [2];
    logic [15:0] m_dalja [2];
    bit          m_carry [2];
    bit          m_zero  [2];
    logic [15:0] m_pres  [2];
    bit          m_pc    [2];
    bit          mvalid = 1'b0;
    int          steps   [2] = '{1, 4};

    task automatic model_step(input int i);
        logic [15:0] r;
        bit          c;
        int          k;
        int          cnt;
        cnt = m_cnt[i];
        if (rst) begin
            cnt = 0;
            m_done[i]  <= 1'b0;
            m_dalja[i] <= 16'h0;
            m_carry[i] <= 1'b0;
            m_zero[i]  <= 1'b1;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            m_done[i] <= (cnt == 0);
            if (cnt == 0) begin
                m_dalja[i] <= m_pres[i];
                m_carry[i] <= m_pc[i];
                m_zero[i]  <= (m_pres[i] == 16'h0);
            end
        end else begin
            m_done[i] <= 1'b0;
            if (start) begin
                ref_op(mode, hyrja, int'(shamt), r, c);
                k = (mode > 3'd4) ? 0 : int'(ceil_div(int'(shamt), steps[i]));
                if (k == 0) begin
                    m_done[i]  <= 1'b1;
                    m_dalja[i] <= r;
                    m_carry[i] <= c;
                    m_zero[i]  <= (r == 16'h0);
                end else begin
                    cnt = k;
                    m_pres[i] <= r;
                    m_pc[i]   <= c;
                end
            end
        end
        m_cnt[i]  <= cnt;
        m_busy[i] <= (cnt > 0);
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        mvalid <= mvalid | rst;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cyc busy[%0d]", i),  int'(busy_w[i]),  int'(m_busy[i]));
                check($sformatf("cyc done[%0d]", i),  int'(done_w[i]),  int'(m_done[i]));
                check($sformatf("cyc dalja[%0d]", i), int'(dalja_w[i]), int'(m_dalja[i]));
                check($sformatf("cyc carry[%0d]", i), int'(carry_w[i]), int'(m_carry[i]));
                check($sformatf("cyc zero[%0d]", i),  int'(zero_w[i]),  int'(m_zero[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble inputs after accept, then check latency and literal result.
    task automatic run_op(input string nm, input int w, input logic [2:0] md, input logic [15:0] a,
                          input logic [3:0] n, input logic [15:0] ed, input bit ec, input int el);
        int lat;
        int bc;
        lat = -1;
        bc  = 0;
        start = 1'b1; mode = md; hyrja = a; shamt = n;
        tick();
        start = 1'b0; mode = 3'd7; hyrja = ~a; shamt = ~n;
        for (int e = 0; e <= 40; e++) begin
            if (done_w[w]) begin
                lat = e;
                break;
            end
            if (busy_w[w]) bc++;
            tick();
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no done within 40 cycles", nm);
        end else begin
            check({nm, " latency"}, lat, el);
            check({nm, " busy cycles"}, bc, el);
            check({nm, " dalja"}, int'(dalja_w[w]), int'(ed));
            check({nm, " carry"}, int'(carry_w[w]), int'(ec));
            check({nm, " zero"}, int'(zero_w[w]), int'(ed == 16'h0));
        end
    endtask

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; mode = 3'd0; hyrja = 16'h0; shamt = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", int'(busy_w[0]), 0);
        check("reset done", int'(done_w[0]), 0);
        check("reset dalja", int'(dalja_w[0]), 0);
        check("reset carry", int'(carry_w[0]), 0);
        check("reset zero", int'(zero_w[0]), 1);

        run_op("sra", 0, MODE_SRA, 16'h800F, 4'd4, 16'hF800, 1'b1, 4);
        tick();
        tick();

        // Abort an SRA by 8 with a two-cycle reset; no done may follow.
        start = 1'b1; mode = MODE_SRA; hyrja = 16'h8000; shamt = 4'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("abort busy", int'(busy_w[0]), 0);
        check("abort done", int'(done_w[0]), 0);
        check("abort dalja", int'(dalja_w[0]), 0);
        check("abort zero", int'(zero_w[0]), 1);
        dc = 0;
        repeat (12) begin
            tick();
            dc += int'(done_w[0]);
        end
        check("abort done pulses", dc, 0);

        run_op("srl", 0, MODE_SRL, 16'h800F, 4'd4, 16'h0800, 1'b1, 4);
        run_op("rol", 0, MODE_ROL, 16'h8001, 4'd1, 16'h0003, 1'b1, 1);
        run_op("ror", 0, MODE_ROR, 16'h0001, 4'd1, 16'h8000, 1'b1, 1);
        run_op("srl zero", 0, MODE_SRL, 16'h0001, 4'd1, 16'h0000, 1'b1, 1);
        repeat (3) tick();

        run_op("sll step4", 1, MODE_SLL, 16'h00FF, 4'd15, 16'h8000, 1'b1, 4);
        repeat (20) tick();

        run_op("shamt0", 0, MODE_SLL, 16'h1234, 4'd0, 16'h1234, 1'b0, 0);
        run_op("b2b sra", 0, MODE_SRA, 16'hFFFF, 4'd3, 16'hFFFF, 1'b1, 3);
        run_op("reserved", 0, 3'd5, 16'hABCD, 4'd7, 16'hABCD, 1'b0, 0);
        repeat (2) tick();

        // A start pulse during SHIFT must be dropped: exactly one done, from the first op.
        start = 1'b1; mode = MODE_SRL; hyrja = 16'hF0F0; shamt = 4'd6;
        tick();
        start = 1'b0;
        dc = 0;
        tick();
        dc += int'(done_w[0]);
        tick();
        dc += int'(done_w[0]);
        start = 1'b1; mode = MODE_ROL; hyrja = 16'h0001; shamt = 4'd1;
        tick();
        dc += int'(done_w[0]);
        start = 1'b0;
        repeat (10) begin
            tick();
            dc += int'(done_w[0]);
        end
        check("busy-start done count", dc, 1);
        check("busy-start dalja", int'(dalja_w[0]), 'h03C3);
        check("busy-start carry", int'(carry_w[0]), 1);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
